// File: rtl/aes_dec_key_prep_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_dec_key_prep_pkg
// Description : Shared constants, FSM encoding and GF(2^8) helper for the
//               AES-128 decrypt key preparation block.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_dec_key_prep_pkg;

    // AES-128 round count; also the final value of the round counter
    localparam int         AES_NR        = 10;
    localparam logic [3:0] ROUND_LAST    = 4'(AES_NR);

    // Round-constant seeds: forward expansion start and decrypt-core start
    localparam logic [7:0] RCON_INIT     = 8'h01;
    localparam logic [7:0] RCON_DEC_INIT = 8'h36;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] XTIME_POLY    = 8'h1b;

    // Key preparation FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Multiply by x in GF(2^8): shift left, reduce when the top bit falls out
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_round.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_key_expand_round
// Description : One combinational step of forward AES-128 key expansion:
//               next round key from the current round key and rcon.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand_round (
    input  logic [127:0] i_key,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_key[127:96];
    assign w_w1 = i_key[95:64];
    assign w_w2 = i_key[63:32];
    assign w_w3 = i_key[31:0];

    // RotWord: leading byte of w3 moves to the end
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    // SubWord: one S-box per byte lane
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {i_rcon, 24'h000000};

    // Each new word chains from the previously produced new word
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Forward AES S-box, purely combinational table lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Byte 0x00 occupies the most significant byte of the table
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry i sits (255 - i) bytes above bit 0; 255 - i is ~i for 8 bits
    logic [10:0] w_bit_idx;
    assign w_bit_idx = {~i_byte, 3'b000};
    assign o_byte    = c_sbox[w_bit_idx +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_dec_key_prep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_dec_key_prep
// Description : Iterative AES-128 forward key expansion, one round per cycle,
//               producing the round-10 key that seeds the decrypt core.
//               The result is cached in DONE until a new key is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_dec_key_prep (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_v_i,
    input  logic [127:0] key_i,
    output logic         key_ready_o,
    output logic         dec_key_v_o,
    output logic [127:0] dec_key_o,
    output logic [7:0]   dec_rcon_o
);

    import aes_dec_key_prep_pkg::*;

    state_t       r_state;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic [127:0] r_key;
    logic         r_key_ready;
    logic         r_dec_key_v;

    logic [127:0] w_next_key;
    logic         w_transfer;

    assign w_transfer = key_v_i & r_key_ready;

    aes_key_expand_round u_round (
        .i_key  (r_key),
        .i_rcon (r_rcon),
        .o_key  (w_next_key)
    );

    // Key preparation FSM: load, expand ten rounds, then hold the result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_round     <= 4'd0;
            r_rcon      <= RCON_INIT;
            r_dec_key_v <= 1'b0;
            r_key_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_transfer) begin
                        r_key       <= key_i;
                        r_round     <= 4'd1;
                        r_rcon      <= RCON_INIT;
                        r_state     <= ST_EXPAND;
                        r_dec_key_v <= 1'b0;
                        r_key_ready <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    r_key  <= w_next_key;
                    r_rcon <= xtime(r_rcon);
                    // Counter saturates at the last round rather than wrapping
                    if (r_round == ROUND_LAST) begin
                        r_state     <= ST_DONE;
                        r_dec_key_v <= 1'b1;
                        r_key_ready <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_round     <= 4'd0;
                    r_rcon      <= RCON_INIT;
                    r_dec_key_v <= 1'b0;
                    r_key_ready <= 1'b1;
                end
            endcase
        end
    end

    assign key_ready_o = r_key_ready;
    assign dec_key_v_o = r_dec_key_v;
    assign dec_key_o   = r_key;
    assign dec_rcon_o  = RCON_DEC_INIT;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_key_prep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_dec_key_prep
// Description : Directed self-checking bench for aes_dec_key_prep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dec_key_prep;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_v_i;
    logic [127:0] key_i;
    logic         key_ready_o;
    logic         dec_key_v_o;
    logic [127:0] dec_key_o;
    logic [7:0]   dec_rcon_o;

    int tests  = 0;
    int failed = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] E1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] E2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_dec_key_prep dut (
        .clk         (clk),
        .reset       (reset),
        .key_v_i     (key_v_i),
        .key_i       (key_i),
        .key_ready_o (key_ready_o),
        .dec_key_v_o (dec_key_v_o),
        .dec_key_o   (dec_key_o),
        .dec_rcon_o  (dec_rcon_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; transfers on the next posedge, returns at the following negedge
    task automatic send_key(input logic [127:0] k, input string tag);
        key_v_i = 1'b1;
        key_i   = k;
        @(posedge clk);
        #1;
        key_v_i = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after_xfer"}, {127'd0, key_ready_o}, 128'd0);
        chk({tag, "_valid_after_xfer"}, {127'd0, dec_key_v_o}, 128'd0);
    endtask

    // Walks edges N+1..N+10; optionally pulses key_v_i with another key mid-expansion
    task automatic expect_result(input logic [127:0] exp, input string tag,
                                 input int pulse_at, input logic [127:0] pulse_key);
        for (int c = 1; c <= 10; c++) begin
            if (c == pulse_at) begin
                key_v_i = 1'b1;
                key_i   = pulse_key;
            end
            @(negedge clk);
            key_v_i = 1'b0;
            if (c < 10) begin
                chk($sformatf("%s_valid_early_%0d", tag, c), {127'd0, dec_key_v_o}, 128'd0);
                chk($sformatf("%s_ready_busy_%0d", tag, c), {127'd0, key_ready_o}, 128'd0);
            end
        end
        chk({tag, "_valid"}, {127'd0, dec_key_v_o}, 128'd1);
        chk({tag, "_ready"}, {127'd0, key_ready_o}, 128'd1);
        chk({tag, "_key"},   dec_key_o, exp);
    endtask

    initial begin
        reset   = 1'b1;
        key_v_i = 1'b0;
        key_i   = '0;
        repeat (3) @(negedge clk);
        chk("rcon_in_reset",  {120'd0, dec_rcon_o}, 128'h36);
        chk("reset_ready",    {127'd0, key_ready_o}, 128'd1);
        chk("reset_valid",    {127'd0, dec_key_v_o}, 128'd0);
        reset = 1'b0;

        // FIPS-197 key, exact ten-cycle latency
        send_key(K1, "k1");
        expect_result(E1, "k1", 0, '0);

        // Back-to-back: new key accepted in the first DONE cycle
        send_key(K2, "b2b");
        expect_result(E2, "k2", 0, '0);

        // Result and flags held in DONE
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold_key_%0d", i),   dec_key_o, E2);
            chk($sformatf("hold_valid_%0d", i), {127'd0, dec_key_v_o}, 128'd1);
        end
        chk("hold_ready", {127'd0, key_ready_o}, 128'd1);
        chk("rcon_run",   {120'd0, dec_rcon_o}, 128'h36);

        // key_v_i pulsed mid-expansion must be ignored
        send_key(K1, "pulse");
        expect_result(E1, "pulse", 3, K2);

        // Reset at the edge where the counter reads 5 discards the key
        send_key(K1, "abort");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", {127'd0, key_ready_o}, 128'd1);
        chk("abort_valid", {127'd0, dec_key_v_o}, 128'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("abort_no_valid_%0d", i), {127'd0, dec_key_v_o}, 128'd0);
        end

        // Reset wins over a simultaneous transfer
        reset   = 1'b1;
        key_v_i = 1'b1;
        key_i   = K2;
        @(negedge clk);
        reset   = 1'b0;
        key_v_i = 1'b0;
        chk("prio_ready", {127'd0, key_ready_o}, 128'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("prio_no_valid_%0d", i), {127'd0, dec_key_v_o}, 128'd0);
            chk($sformatf("prio_ready_%0d", i),    {127'd0, key_ready_o}, 128'd1);
        end

        // Fresh key completes normally after the aborts
        send_key(K2, "fresh");
        expect_result(E2, "fresh", 0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_dec_key_prep.md
AES_DEC_KEY_PREP -- requirements
Module: aes_dec_key_prep

Interface
REQ-001 SHALL have no parameters; AES-128 only (10 rounds).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 key_v_i  input  1  cipher key valid; a transfer occurs when key_v_i & key_ready_o on a rising edge.
REQ-005 key_i  input  128  AES-128 cipher key; key_i[127:120] is byte 0, word w0 = key_i[127:96].
REQ-006 key_ready_o  output  1  block can accept a new cipher key.
REQ-007 dec_key_v_o  output  1  dec_key_o holds the round-10 key, ready for the decrypt core.
REQ-008 dec_key_o  output  128  round-10 key (w40..w43), same byte order as key_i.
REQ-009 dec_rcon_o  output  8  decrypt-core initial rcon, constant 8'h36.

Function
REQ-010 SHALL run forward AES-128 key expansion iteratively, one round key per cycle, to produce the last round key that the decrypt core consumes as its starting key.
REQ-011 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-012 IDLE: key_ready_o=1, dec_key_v_o=0; on transfer, load key_i into the key register, set round counter to 1, rcon to 8'h01, go to EXPAND.
REQ-013 EXPAND: key_ready_o=0, dec_key_v_o=0, key_v_i ignored; each cycle: key <= next_round(key, rcon), rcon <= xtime(rcon), counter += 1.
REQ-014 next_round: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-015 xtime: rcon<<1, XOR 8'h1b when rcon[7]=1; rcon sequence 01,02,04,08,10,20,40,80,1b,36.
REQ-016 After the round computed with rcon 8'h36 (counter==10), SHALL go to DONE.
REQ-017 Latency: transfer on edge N -> dec_key_v_o=1 and dec_key_o valid from edge N+10.
REQ-018 DONE: dec_key_v_o=1, key_ready_o=1, dec_key_o held stable for any number of cycles (key cache reused across blocks).
REQ-019 DONE with transfer: load new key, go to EXPAND; dec_key_v_o=0 from the next edge.
REQ-020 Counter SHALL be 4 bits, never exceed 10, and never wrap.
REQ-021 dec_key_o SHALL equal the key register directly (registered, no combinational path from key_i).
REQ-022 dec_rcon_o SHALL be 8'h36 at all times, including during reset.

Reset
REQ-023 While reset=1 at an edge: state<=IDLE, counter<=0, rcon<=8'h01, dec_key_v_o=0, key_ready_o=1 from the following cycle.
REQ-024 Reset during EXPAND or DONE SHALL abort and discard the key; no valid is produced for the aborted key.
REQ-025 Key register need not be reset; dec_key_o is don't-care while dec_key_v_o=0.
REQ-026 Reset SHALL take priority over a simultaneous key transfer.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding, AES_NR=10, RCON_INIT=8'h01, RCON_DEC_INIT=8'h36, xtime polynomial 8'h1b.
REQ-028 SHALL instantiate one combinational sub-module, aes_key_expand_round (key, rcon in; next key out), which uses four instances of the codebase forward S-box.
REQ-029 Total RTL is 120-400 lines; no extra pipeline stages.

Verification
REQ-030 Key 000102030405060708090a0b0c0d0e0f -> dec_key_o=13111d7fe3944a17f307a78b4d2b30c5, valid exactly 10 cycles after transfer.
REQ-031 Key 2b7e151628aed2a6abf7158809cf4f3c -> d014f9a8c9ee2589e13f0cc8b6630ca6; outputs held stable for 20 cycles in DONE.
REQ-032 key_v_i pulsed during EXPAND with a different key -> ignored; result matches the first key at N+10.
REQ-033 Back-to-back: new key transferred in the first DONE cycle -> valid drops next cycle, second result valid 10 cycles after the second transfer.
REQ-034 Reset asserted at counter 5 -> IDLE, valid stays 0, key_ready_o=1; a fresh key then completes normally.
REQ-035 End-to-end: output fed to the AES decrypt core with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff.
